// File: rtl/mul_pipe.sv
// mul_pipe: parametrised in-order pipelined integer multiplier.
// Valid/ready handshake with collapsing bubbles, flush and tag passthrough.
module mul_pipe #(
  parameter int XLEN  = 32,
  parameter int LAT   = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  logic [LAT-1:0]    vld;
  logic [LAT-1:0]    adv;
  logic [XLEN-1:0]   res [LAT];
  logic [TAG_W-1:0]  tag [LAT];
  logic              free;
  logic              acc;

  logic              sx;
  logic              hi_sel;
  logic [2*XLEN-1:0] a_w;
  logic [2*XLEN-1:0] b_w;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   res_in;

  // Low 2*XLEN bits of the extended product are exact for both signednesses.
  always_comb begin
    sx     = (in_op == 2'b01);
    hi_sel = (in_op == 2'b01) || (in_op == 2'b10);
    a_w    = {{XLEN{sx & in_src1[XLEN-1]}}, in_src1};
    b_w    = {{XLEN{sx & in_src2[XLEN-1]}}, in_src2};
    prod   = a_w * b_w;
    res_in = hi_sel ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  // free: the stage below can take a new entry this cycle.
  always_comb begin
    adv  = '0;
    free = out_ready;
    for (int k = LAT-1; k >= 0; k--) begin
      adv[k] = vld[k] & free;
      free   = ~vld[k] | free;
    end
    in_ready = ~flush & free;
  end

  assign acc = in_valid & in_ready;

  for (genvar k = 0; k < LAT; k++) begin : g_st
    logic             v_q;
    logic [XLEN-1:0]  r_q;
    logic [TAG_W-1:0] t_q;
    logic             ld;
    logic [XLEN-1:0]  r_d;
    logic [TAG_W-1:0] t_d;

    if (k == 0) begin : g_in
      assign ld  = acc;
      assign r_d = res_in;
      assign t_d = in_tag;
    end else begin : g_mid
      assign ld  = adv[k-1];
      assign r_d = res[k-1];
      assign t_d = tag[k-1];
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        v_q <= 1'b0;
        r_q <= '0;
        t_q <= '0;
      end else if (flush) begin
        v_q <= 1'b0;
      end else if (ld) begin
        v_q <= 1'b1;
        r_q <= r_d;
        t_q <= t_d;
      end else if (adv[k]) begin
        v_q <= 1'b0;
      end
    end

    assign vld[k] = v_q;
    assign res[k] = r_q;
    assign tag[k] = t_q;
  end

  assign out_valid  = vld[LAT-1];
  assign out_result = res[LAT-1];
  assign out_tag    = tag[LAT-1];

endmodule
